// File: rtl/first_nios2_system_sysid_pkg.sv
// rtl/first_nios2_system_sysid_pkg.sv - shared types and constants for the sysid checker
package first_nios2_system_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_ID  = 3'd1,
        ST_LAT_ID = 3'd2,
        ST_RD_TS  = 3'd3,
        ST_LAT_TS = 3'd4,
        ST_CHECK  = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ID      = 2'd1;
    localparam logic [1:0] ERR_TS      = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/first_nios2_system_avm_read_unit.sv
// rtl/first_nios2_system_avm_read_unit.sv - single Avalon-MM read with stall timeout and fixed latency
module first_nios2_system_avm_read_unit #(
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        lat_i,
    input  logic        waitrequest_i,
    input  logic [31:0] readdata_i,
    output logic        read_o,
    output logic        accepted_o,
    output logic        data_valid_o,
    output logic        timed_out_o,
    output logic [31:0] data_o
);

    localparam logic        ZERO_LAT  = (READ_LATENCY == 0);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  LAT_LAST  = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    logic [15:0] wait_q, wait_d;
    logic [1:0]  lat_q, lat_d;

    assign read_o      = req_i;
    assign accepted_o  = req_i & ~waitrequest_i;
    // Timeout fires on the edge where the stall count would reach the limit.
    assign timed_out_o = req_i & waitrequest_i & (wait_q >= WAIT_LAST);
    assign data_o      = readdata_i;

    always_comb begin
        data_valid_o = 1'b0;
        if (ZERO_LAT) begin
            data_valid_o = accepted_o;
        end else begin
            data_valid_o = lat_i & (lat_q == LAT_LAST);
        end
    end

    always_comb begin
        wait_d = 16'd0;
        if (req_i && waitrequest_i) begin
            wait_d = (wait_q == 16'hFFFF) ? wait_q : wait_q + 16'd1;
        end
    end

    always_comb begin
        lat_d = 2'd0;
        if (lat_i) begin
            lat_d = (lat_q == 2'd3) ? lat_q : lat_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_q <= 16'd0;
            lat_q  <= 2'd0;
        end else begin
            wait_q <= wait_d;
            lat_q  <= lat_d;
        end
    end

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// rtl/first_nios2_system_sysid_checker.sv - reads sysid ID and timestamp, compares, retries, reports
module first_nios2_system_sysid_checker
    import first_nios2_system_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1363390307,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  error_code,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

    state_e      state_q, state_d;
    logic        pass_q, pass_d;
    logic        done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;
    logic [3:0]  retry_q, retry_d;

    logic        in_rd, in_lat;
    logic        rd_accepted, rd_valid, rd_timed_out;
    logic [31:0] rd_data;

    assign in_rd  = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
    assign in_lat = (state_q == ST_LAT_ID) || (state_q == ST_LAT_TS);
    assign m_address = ((state_q == ST_RD_TS) || (state_q == ST_LAT_TS)) ? SYSID_ADDR_TS
                                                                         : SYSID_ADDR_ID;

    first_nios2_system_avm_read_unit #(
        .READ_LATENCY   (READ_LATENCY),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_read (
        .clk_i         (clock),
        .rst_i         (reset),
        .req_i         (in_rd),
        .lat_i         (in_lat),
        .waitrequest_i (m_waitrequest),
        .readdata_i    (m_readdata),
        .read_o        (m_read),
        .accepted_o    (rd_accepted),
        .data_valid_o  (rd_valid),
        .timed_out_o   (rd_timed_out),
        .data_o        (rd_data)
    );

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        err_d   = err_q;
        id_d    = id_q;
        ts_d    = ts_q;
        retry_d = retry_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pass_d  = 1'b0;
                    err_d   = ERR_NONE;
                    retry_d = 4'd0;
                    state_d = ST_RD_ID;
                end
            end
            ST_RD_ID, ST_RD_TS: begin
                if (rd_timed_out) begin
                    pass_d  = 1'b0;
                    err_d   = ERR_TIMEOUT;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (rd_valid) begin
                    if (state_q == ST_RD_ID) begin
                        id_d    = rd_data;
                        state_d = ST_RD_TS;
                    end else begin
                        ts_d    = rd_data;
                        state_d = ST_CHECK;
                    end
                end else if (rd_accepted) begin
                    state_d = (state_q == ST_RD_ID) ? ST_LAT_ID : ST_LAT_TS;
                end
            end
            ST_LAT_ID: begin
                if (rd_valid) begin
                    id_d    = rd_data;
                    state_d = ST_RD_TS;
                end
            end
            ST_LAT_TS: begin
                if (rd_valid) begin
                    ts_d    = rd_data;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS)) begin
                    pass_d  = 1'b1;
                    err_d   = ERR_NONE;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (retry_q < RETRY_LIMIT) begin
                    retry_d = retry_q + 4'd1;
                    state_d = ST_RD_ID;
                end else begin
                    // ID mismatch wins when both words are wrong.
                    pass_d  = 1'b0;
                    err_d   = (id_q != EXPECTED_ID) ? ERR_ID : ERR_TS;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= ERR_NONE;
            id_q    <= 32'd0;
            ts_q    <= 32'd0;
            retry_q <= 4'd0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            err_q   <= err_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
            retry_q <= retry_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign pass       = pass_q;
    assign error_code = err_q;
    assign id_value   = id_q;
    assign ts_value   = ts_q;

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// tb/tb_first_nios2_system_sysid_checker.sv - self-checking bench for the sysid checker
module tb_first_nios2_system_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1363390307;
    localparam int          TMO    = 8;
    localparam int          MAXR   = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start         [2] = '{1'b0, 1'b0};
    logic        m_address     [2];
    logic        m_read        [2];
    logic        m_waitrequest [2];
    logic [31:0] m_readdata    [2];
    logic        busy          [2];
    logic        done          [2];
    logic        pass          [2];
    logic [1:0]  error_code    [2];
    logic [31:0] id_value      [2];
    logic [31:0] ts_value      [2];

    // Instance 0: zero latency; instance 1: two cycles of read latency.
    first_nios2_system_sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(0),
        .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MAXR)
    ) dut_a (
        .clock(clk), .reset(reset), .start(start[0]),
        .m_address(m_address[0]), .m_read(m_read[0]),
        .m_waitrequest(m_waitrequest[0]), .m_readdata(m_readdata[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .error_code(error_code[0]),
        .id_value(id_value[0]), .ts_value(ts_value[0])
    );

    first_nios2_system_sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .READ_LATENCY(2),
        .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MAXR)
    ) dut_b (
        .clock(clk), .reset(reset), .start(start[1]),
        .m_address(m_address[1]), .m_read(m_read[1]),
        .m_waitrequest(m_waitrequest[1]), .m_readdata(m_readdata[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .error_code(error_code[1]),
        .id_value(id_value[1]), .ts_value(ts_value[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] actual=%0d required=%0d", nm, idx, act, exp);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    // Slave model configuration
    logic        stuck    [2] = '{1'b0, 1'b0};
    int          stall_ts [2] = '{0, 0};
    logic [31:0] id_word  [2] = '{EXP_ID, EXP_ID};
    logic [31:0] ts_word  [2] = '{EXP_TS, EXP_TS};

    int   scnt     [2];
    int   pcnt     [2];
    logic paddr    [2];
    logic ev_acc   [2] = '{1'b0, 1'b0};
    logic ev_stall [2] = '{1'b0, 1'b0};
    logic ev_addr  [2] = '{1'b0, 1'b0};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            m_waitrequest[i] = stuck[i] || (m_read[i] && m_address[i] && (scnt[i] < stall_ts[i]));
            m_readdata[i] = 32'hDEAD_BEEF;
            if (lat_of(i) == 0) begin
                if (m_read[i] && !m_waitrequest[i])
                    m_readdata[i] = m_address[i] ? ts_word[i] : id_word[i];
            end else if (pcnt[i] == 1) begin
                m_readdata[i] = paddr[i] ? ts_word[i] : id_word[i];
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                scnt[i]  <= 0;
                pcnt[i]  <= 0;
                paddr[i] <= 1'b0;
            end else begin
                if (ev_stall[i])    scnt[i] <= scnt[i] + 1;
                else if (ev_acc[i]) scnt[i] <= 0;
                if (ev_acc[i]) begin
                    pcnt[i]  <= lat_of(i);
                    paddr[i] <= ev_addr[i];
                end else if (pcnt[i] > 0) begin
                    pcnt[i] <= pcnt[i] - 1;
                end
            end
        end
    end

    // Behavioural model: outcome and duration of a whole check computed from the slave setup.
    function automatic logic words_ok(input int i);
        return (id_word[i] == EXP_ID) && (ts_word[i] == EXP_TS);
    endfunction

    function automatic int dur(input int i);
        int l = lat_of(i);
        int seq;
        if (stuck[i]) return TMO;
        seq = (1 + l) + (1 + stall_ts[i] + l) + 1;
        return words_ok(i) ? seq : seq * (MAXR + 1);
    endfunction

    function automatic logic [1:0] exp_err(input int i);
        if (stuck[i])    return 2'd3;
        if (words_ok(i)) return 2'd0;
        return (id_word[i] != EXP_ID) ? 2'd1 : 2'd2;
    endfunction

    int          left     [2];
    logic        done_exp [2];
    logic        e_pass   [2];
    logic [1:0]  e_err    [2];
    logic [31:0] e_id     [2];
    logic [31:0] e_ts     [2];
    logic        p_pass   [2];
    logic [1:0]  p_err    [2];
    logic [31:0] p_id     [2];
    logic [31:0] p_ts     [2];
    logic        p_upd    [2];

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                left[i] <= 0; done_exp[i] <= 1'b0; e_pass[i] <= 1'b0; e_err[i] <= 2'd0;
                e_id[i] <= 32'd0; e_ts[i] <= 32'd0; p_upd[i] <= 1'b0;
                p_pass[i] <= 1'b0; p_err[i] <= 2'd0; p_id[i] <= 32'd0; p_ts[i] <= 32'd0;
            end else begin
                done_exp[i] <= 1'b0;
                if (left[i] > 0) begin
                    left[i] <= left[i] - 1;
                    if (left[i] == 1) begin
                        done_exp[i] <= 1'b1;
                        e_pass[i]   <= p_pass[i];
                        e_err[i]    <= p_err[i];
                        if (p_upd[i]) begin
                            e_id[i] <= p_id[i];
                            e_ts[i] <= p_ts[i];
                        end
                    end
                end else if (start[i]) begin
                    left[i]   <= dur(i);
                    p_pass[i] <= !stuck[i] && words_ok(i);
                    p_err[i]  <= exp_err(i);
                    p_id[i]   <= id_word[i];
                    p_ts[i]   <= ts_word[i];
                    p_upd[i]  <= !stuck[i];
                end
            end
        end
    end

    // Per-cycle compare and activity counters
    logic        prev_stall [2] = '{1'b0, 1'b0};
    logic        prev_addr  [2] = '{1'b0, 1'b0};
    int          rd_hi      [2] = '{0, 0};
    int          acc        [2] = '{0, 0};
    logic        addr_log   [$];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("busy", i, busy[i], left[i] > 0);
            chk("done", i, done[i], done_exp[i]);
            if (left[i] == 0) begin
                chk("pass", i, pass[i], e_pass[i]);
                chk("error_code", i, error_code[i], e_err[i]);
                chk("id_value", i, id_value[i], e_id[i]);
                chk("ts_value", i, ts_value[i], e_ts[i]);
            end else begin
                chk("pass_busy", i, pass[i], 1'b0);
                chk("err_busy", i, error_code[i], 2'd0);
            end
            if (m_read[i]) chk("read_only_busy", i, busy[i], 1'b1);
            if (!reset && prev_stall[i] && left[i] > 0) begin
                chk("stall_read_hold", i, m_read[i], 1'b1);
                chk("stall_addr_hold", i, m_address[i], prev_addr[i]);
            end
            prev_stall[i] <= !reset && m_read[i] && m_waitrequest[i];
            prev_addr[i]  <= m_address[i];
            ev_acc[i]     <= !reset && m_read[i] && !m_waitrequest[i];
            ev_stall[i]   <= !reset && m_read[i] && m_waitrequest[i];
            ev_addr[i]    <= m_address[i];
            if (m_read[i]) rd_hi[i] <= rd_hi[i] + 1;
            if (m_read[i] && !m_waitrequest[i]) acc[i] <= acc[i] + 1;
        end
        if (m_read[0] && !m_waitrequest[0]) addr_log.push_back(m_address[0]);
    end

    // Counts clock edges after the accepting edge until done is seen.
    task automatic wait_done(input int i, input int bound, output int n);
        logic found = 1'b0;
        n = 0;
        for (int k = 0; k < bound; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done[i]) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("done_timeout", i, 32'd0, 32'd1);
    endtask

    task automatic run_check(input int i, input int bound, output int n);
        @(posedge clk); #2; start[i] = 1'b1;
        @(posedge clk); #2; start[i] = 1'b0;
        wait_done(i, bound, n);
    endtask

    int n, r0, a0, dc;

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", 0, busy[0], 1'b0);
        chk("rst_read", 0, m_read[0], 1'b0);
        chk("rst_addr", 0, m_address[0], 1'b0);
        chk("rst_id", 1, id_value[1], 32'd0);
        reset = 1'b0;

        // Zero-wait match
        addr_log.delete();
        r0 = rd_hi[0];
        run_check(0, 50, n);
        chk("t1_cycles", 0, n, 3);
        chk("t1_pass", 0, pass[0], 1'b1);
        chk("t1_err", 0, error_code[0], 2'd0);
        chk("t1_ts", 0, ts_value[0], 32'd1363390307);
        chk("t1_read_cycles", 0, rd_hi[0] - r0, 2);
        chk("t1_nreads", 0, addr_log.size(), 2);
        if (addr_log.size() == 2) begin
            chk("t1_addr0", 0, addr_log[0], 1'b0);
            chk("t1_addr1", 0, addr_log[1], 1'b1);
        end

        // ID mismatch, retries exhausted
        id_word[0] = 32'h0000_0005;
        a0 = acc[0];
        run_check(0, 100, n);
        chk("t2_cycles", 0, n, 12);
        chk("t2_reads", 0, acc[0] - a0, 8);
        chk("t2_pass", 0, pass[0], 1'b0);
        chk("t2_err", 0, error_code[0], 2'd1);
        chk("t2_id", 0, id_value[0], 32'd5);
        id_word[0] = EXP_ID;

        // TS stall with read latency
        stall_ts[1] = 4;
        r0 = rd_hi[1]; a0 = acc[1];
        run_check(1, 100, n);
        chk("t3_cycles", 1, n, 11);
        chk("t3_pass", 1, pass[1], 1'b1);
        chk("t3_reads", 1, acc[1] - a0, 2);
        chk("t3_read_cycles", 1, rd_hi[1] - r0, 6);

        // Stuck waitrequest -> timeout, no retry
        stuck[0] = 1'b1;
        r0 = rd_hi[0]; a0 = acc[0];
        run_check(0, 100, n);
        chk("t4_cycles", 0, n, 8);
        chk("t4_err", 0, error_code[0], 2'd3);
        chk("t4_pass", 0, pass[0], 1'b0);
        chk("t4_id_kept", 0, id_value[0], 32'd5);
        repeat (5) @(negedge clk);
        chk("t4_read_cycles", 0, rd_hi[0] - r0, 8);
        chk("t4_reads", 0, acc[0] - a0, 0);
        stuck[0] = 1'b0;

        // Reset during the TS stall
        @(posedge clk); #2; start[1] = 1'b1;
        @(posedge clk); #2; start[1] = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("t5_pre_read", 1, m_read[1], 1'b1);
        chk("t5_pre_addr", 1, m_address[1], 1'b1);
        reset = 1'b1;
        #1;
        chk("t5_read", 1, m_read[1], 1'b0);
        chk("t5_busy", 1, busy[1], 1'b0);
        chk("t5_done", 1, done[1], 1'b0);
        chk("t5_pass", 1, pass[1], 1'b0);
        chk("t5_err", 1, error_code[1], 2'd0);
        chk("t5_id", 1, id_value[1], 32'd0);
        chk("t5_ts", 1, ts_value[1], 32'd0);
        @(posedge clk); #2; reset = 1'b0;
        stall_ts[1] = 0;
        run_check(1, 50, n);
        chk("t5_clean_cycles", 1, n, 7);
        chk("t5_clean_pass", 1, pass[1], 1'b1);
        chk("t5_clean_ts", 1, ts_value[1], EXP_TS);

        // Start while busy is ignored
        a0 = acc[0]; dc = 0;
        @(posedge clk); #2; start[0] = 1'b1;
        @(posedge clk); #2; start[0] = 1'b0;
        @(posedge clk); #2; start[0] = 1'b1;
        @(posedge clk); #2; start[0] = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done[0]) dc++;
        end
        chk("t6_done_pulses", 0, dc, 1);
        chk("t6_reads", 0, acc[0] - a0, 2);

        // Start in the done cycle is accepted
        run_check(0, 50, n);
        #1; start[0] = 1'b1;
        @(posedge clk); #2; start[0] = 1'b0;
        wait_done(0, 50, n);
        chk("t7_back_to_back", 0, n, 3);
        chk("t7_pass", 0, pass[0], 1'b1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/first_nios2_system_sysid_checker.md
Name: first_nios2_system_sysid_checker

Overview:
- Avalon-MM read master that interrogates a sysid control slave after start, with bounded retry.
- Reads word 0 (system ID) and word 1 (build timestamp), compares each against expected parameters, and reports pass/fail plus the captured values.
- Sits beside the sysid slave in the system so boot-sequencing logic can confirm that the hardware image matches the software build before releasing the CPU.

Parameters:
- EXPECTED_ID, 32'd0, required value at slave address 0
- EXPECTED_TS, 32'd1363390307, required value at slave address 1
- READ_LATENCY, 0, fixed readdata latency in cycles after the accepted read (legal 0..3)
- TIMEOUT_CYCLES, 255, maximum consecutive waitrequest cycles per read (legal 1..65535)
- MAX_RETRIES, 3, extra full ID+TS sequences attempted after a mismatch (legal 0..15)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a check; ignored while busy
- m_address  out  1  slave word address: 0 selects ID, 1 selects TS
- m_read  out  1  Avalon read strobe
- m_waitrequest  in  1  slave stall; tie low for a zero-wait slave
- m_readdata  in  32  slave read data
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- pass  out  1  result, sticky until the next accepted start
- error_code  out  2  0 = none, 1 = ID mismatch, 2 = TS mismatch, 3 = timeout; sticky
- id_value  out  32  last captured ID word
- ts_value  out  32  last captured TS word

Behaviour:
- Reset, asynchronous, all outputs 0:
  - state=IDLE, m_read=0, m_address=0, busy=0, done=0, pass=0
  - error_code=0, id_value=0, ts_value=0, retry and timeout counters 0
  - Reset asserted mid-transaction drops m_read on that edge. No partial result is reported.
- States: IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK.
- IDLE: on start=1, clear pass/error_code and the retry counter, then go to RD_ID.
- RD_ID: m_read=1, m_address=0.
  - While m_waitrequest=1, hold m_read and m_address stable and increment the wait counter.
  - On the first cycle with m_waitrequest=0 the read is accepted and the wait counter clears.
  - READ_LATENCY=0: capture m_readdata into id_value on that edge, then go to RD_TS.
  - Otherwise: go to LAT_ID with m_read=0 and count READ_LATENCY cycles. Capture on the final count edge, then go to RD_TS.
- RD_TS / LAT_TS: same as RD_ID / LAT_ID with m_address=1, capturing into ts_value, then go to CHECK.
- m_read is never asserted in LAT_*, CHECK or IDLE. At most one outstanding read.
- CHECK, one cycle:
  - If both words match: pass=1, error_code=0, done=1, go to IDLE.
  - On a mismatch with retry count < MAX_RETRIES: increment the retry count and go to RD_ID. No done pulse.
  - On a mismatch with retries exhausted: pass=0, done=1, go to IDLE. error_code=1 if the ID differs (ID has priority when both differ), else 2.
- Timeout:
  - Trigger: the wait counter reaches TIMEOUT_CYCLES while still in RD_*.
  - Response on that edge: m_read=0, error_code=3, pass=0, done=1, go to IDLE.
  - A timeout is never retried.
- Timing: with zero-wait, READ_LATENCY=0 and a match, the edge accepting start is E0. ID is captured at E1, TS at E2, and done/pass go high after E3, so busy spans 3 cycles.
- busy = (state != IDLE). done is high only in the cycle following the final CHECK/timeout edge.
- A start in the same cycle that done is high is accepted, since the FSM is already in IDLE.
- Comparisons are full 32-bit equality. Counters saturate and never wrap.

Decomposition:
- Shared package first_nios2_system_sysid_pkg holds:
  - the state enum
  - error_code constants (ERR_NONE, ERR_ID, ERR_TS, ERR_TIMEOUT)
  - address constants SYSID_ADDR_ID=0 and SYSID_ADDR_TS=1
- One natural sub-module: first_nios2_system_avm_read_unit. It performs a single Avalon read with waitrequest/timeout/latency handling and returns data_valid, data and timed_out.
- The checker FSM instantiates that unit once and sequences it.

Test Plan:
- Zero-wait slave returning 0 at address 0 and 1363390307 at address 1, pulse start -> m_read high for exactly 2 cycles (address 0 then 1), done after 3 cycles, pass=1, error_code=0, ts_value=1363390307.
- Slave returns ID 0x00000005, MAX_RETRIES=3 -> 4 full read sequences (8 reads), then done, pass=0, error_code=1, id_value=5.
- m_waitrequest held high for 4 cycles on the TS read, READ_LATENCY=2 -> m_address/m_read stable while stalled, done at 3+4+4=11 cycles, pass=1.
- m_waitrequest stuck high, TIMEOUT_CYCLES=8 -> m_read drops after 8 stall cycles, done pulse, error_code=3, no retry.
- reset asserted during RD_TS stall -> m_read, busy and all result outputs 0 immediately. A subsequent start runs a clean pass.
- start pulsed while busy -> ignored; exactly one done pulse, and the read count is unchanged.
